instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have these ports, one per line as name / direction / width / meaning:
- clk / in / 1 / single clock, rising edge.
- rst_n / in / 1 / reset, synchronous, active-low.
- in_valid / in / 1 / field request valid.
- in_ready / out / 1 / request accepted when in_valid and in_ready are both 1 at a rising edge.
- opcode / in / 4 / instruction opcode.
- rd, rs, rt / in / 4 each / register fields.
- offset_4bit / in / 4 / shift amount, or LW/SW offset.
- immediate_8bit / in / 8 / LLB/LHB immediate.
- offset_9bit / in / 9 / B offset.
- condition / in / 3 / B/BR condition code.
- instr_valid / out / 1 / instruction word valid.
- instr_ready / in / 1 / consumer (decoder side) pops on instr_valid and instr_ready.
- instruction / out / 16 / encoded word at FIFO head.
- count / out / 3 / FIFO occupancy, 0..4.
- halted / out / 1 / HLT accepted; input blocked.
- resume / in / 1 / one-cycle pulse that clears halted.

Function
REQ-002 Accepted fields SHALL be encoded as below; unused bits SHALL be 0.
- 0000-0011 and 0111 (ADD, SUB, XOR, RED, PADDSB): {op, rd, rs, rt}.
- 0100-0110 (SLL, SRA, ROR): {op, rd, rs, offset_4bit}.
- 1000-1001 (LW, SW): {op, rt, rs, offset_4bit}.
- 1010-1011 (LLB, LHB): {op, rd, immediate_8bit}.
- 1100 (B): {op, condition, offset_9bit}.
- 1101 (BR): {op, condition, 1'b0, rs, 4'b0}.
- 1110 (PCS): {op, rd, 8'b0}.
- 1111 (HLT): {op, 12'b0}.
REQ-003 Encoding SHALL be combinational; the encoded word SHALL be written into a 4-entry, 16-bit FIFO on the accepting edge.
REQ-004 Latency: a word accepted at edge N into an empty FIFO SHALL appear on instruction with instr_valid=1 after edge N.
REQ-005 The FIFO SHALL NOT bypass; instr_valid SHALL be 0 in the cycle that a push lands in an empty FIFO.
REQ-006 in_ready SHALL equal (count != 4) and not halted; it SHALL be a function of state only, never of in_valid.
REQ-007 instr_valid SHALL equal (count != 0); instruction SHALL equal the head entry and hold stable while instr_valid=1 and instr_ready=0.
REQ-008 Push and pop in the same cycle SHALL leave count unchanged and keep order. This is legal at count 1..3; at count 4 no push occurs (in_ready=0).
REQ-009 Read and write pointers SHALL be 2 bits and wrap 3 -> 0; count SHALL never exceed 4 or underflow below 0.
REQ-010 On acceptance of HLT (opcode 1111), halted SHALL rise at the same edge, and in_ready SHALL be 0 from the next cycle. The HLT word itself SHALL be queued normally.
REQ-011 resume=1 SHALL clear halted at the next edge. resume while not halted SHALL have no effect.
REQ-012 If resume and an HLT accept occur at the same edge, halted SHALL be 1 after that edge (HLT wins).
REQ-013 The FIFO SHALL continue draining while halted.

Reset
REQ-014 When rst_n=0 at a rising edge, the block SHALL set count=0, both pointers=0, instr_valid=0, halted=0, and instruction=16'h0000; in_ready SHALL be 1 after that edge.
REQ-015 Reset SHALL override any simultaneous push, pop or resume, including mid-stream, and SHALL discard queued words.
REQ-016 FIFO storage contents need not be cleared; instruction SHALL read 0 whenever count=0.

Structure
REQ-017 The following SHALL live in shared package wisc_pkg, for use by both encoder and decoder:
- opcode constants (ADD..HLT);
- field bit positions;
- an encode function.
REQ-018 The FIFO SHALL be one sub-module, instr_fifo, with parameters DEPTH=4 and WIDTH=16; instr_encoder SHALL contain only encode, handshake and halt logic.

Verification
REQ-019 Encode check: ADD rd=3 rs=5 rt=9 -> instruction=16'h0359, instr_valid=1 one cycle after accept.
REQ-020 Encode check: LW rt=2 rs=4 offset_4bit=A -> 16'h824A; B condition=101 offset_9bit=1FF -> 16'hCBFF; BR condition=010 rs=7 -> 16'hD470.
REQ-021 Back-pressure: with instr_ready=0, push 4 words -> count=4 and in_ready=0; the 5th request is held. Raising instr_ready drains all 5 words in push order.
REQ-022 Concurrency: with count=2, push and pop every cycle for 10 cycles -> count stays 2 and no word is lost or duplicated.
REQ-023 Halt: accept HLT -> 16'hF000 is queued, halted=1, in_ready=0. A further request is held until resume; it is accepted 1 cycle after resume. Resume coinciding with an HLT accept leaves halted=1.
REQ-024 Reset: assert rst_n=0 with count=3 and halted=1 -> after the edge count=0, instr_valid=0, halted=0, instruction=0, in_ready=1.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC ISA definitions: opcodes, field positions and the instruction encoder.
// Used by both the encoder front end and the decoder.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int INSTR_W   = 16;
  localparam int OP_LSB    = 12;
  localparam int RD_LSB    = 8;
  localparam int RS_LSB    = 4;
  localparam int RT_LSB    = 0;
  localparam int OFF4_LSB  = 0;
  localparam int IMM8_LSB  = 0;
  localparam int COND_LSB  = 9;
  localparam int OFF9_LSB  = 0;
  // Memory ops place rt in the destination slot.
  localparam int MEMRT_LSB = 8;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] off4;
    logic [7:0] imm8;
    logic [8:0] off9;
    logic [2:0] cond;
  } instr_fields_t;

  function automatic logic [INSTR_W-1:0] encode(input instr_fields_t f);
    logic [INSTR_W-1:0] w;
    w = '0;
    w[OP_LSB +: 4] = f.opcode;
    case (f.opcode)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        w[RD_LSB +: 4] = f.rd;
        w[RS_LSB +: 4] = f.rs;
        w[RT_LSB +: 4] = f.rt;
      end
      OP_SLL, OP_SRA, OP_ROR: begin
        w[RD_LSB +: 4]   = f.rd;
        w[RS_LSB +: 4]   = f.rs;
        w[OFF4_LSB +: 4] = f.off4;
      end
      OP_LW, OP_SW: begin
        w[MEMRT_LSB +: 4] = f.rt;
        w[RS_LSB +: 4]    = f.rs;
        w[OFF4_LSB +: 4]  = f.off4;
      end
      OP_LLB, OP_LHB: begin
        w[RD_LSB +: 4]   = f.rd;
        w[IMM8_LSB +: 8] = f.imm8;
      end
      OP_B: begin
        w[COND_LSB +: 3] = f.cond;
        w[OFF9_LSB +: 9] = f.off9;
      end
      OP_BR: begin
        w[COND_LSB +: 3] = f.cond;
        w[RS_LSB +: 4]   = f.rs;
      end
      OP_PCS:  w[RD_LSB +: 4] = f.rd;
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Non-bypassing circular FIFO; head reads zero when empty.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_count = r_count;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  // Storage is deliberately not reset; the empty mask hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == AW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == AW'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder front end: encodes field requests into 16-bit words,
// queues them for the decoder and blocks input after an HLT until resumed.
module instr_encoder
  import wisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  opcode,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs,
  input  logic [3:0]  rt,
  input  logic [3:0]  offset_4bit,
  input  logic [7:0]  immediate_8bit,
  input  logic [8:0]  offset_9bit,
  input  logic [2:0]  condition,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instruction,
  output logic [2:0]  count,
  output logic        halted,
  input  logic        resume
);
  instr_fields_t      w_fields;
  logic [15:0]        w_word;
  logic               w_accept, w_hlt_acc, w_full, w_empty;
  logic               r_halted;

  assign w_fields = '{opcode: opcode, rd: rd, rs: rs, rt: rt, off4: offset_4bit,
                      imm8: immediate_8bit, off9: offset_9bit, cond: condition};
  assign w_word    = encode(w_fields);
  assign in_ready  = ~w_full & ~r_halted;
  assign w_accept  = in_valid & in_ready;
  assign w_hlt_acc = w_accept & (opcode == OP_HLT);

  // HLT acceptance takes priority over a coincident resume.
  always_ff @(posedge clk) begin
    if (!rst_n)         r_halted <= 1'b0;
    else if (w_hlt_acc) r_halted <= 1'b1;
    else if (resume)    r_halted <= 1'b0;
  end

  instr_fifo #(.DEPTH(4), .WIDTH(16)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_wdata (w_word),
    .i_pop   (instr_ready),
    .o_rdata (instruction),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign instr_valid = ~w_empty;
  assign halted      = r_halted;

endmodule
